// File: rtl/ecc_pkg.sv
// ecc_pkg
//   Constants and FSM encoding shared between the nibble loader (input side)
//   and the kP result unloader (output side) of the ECC point-multiplication
//   core.
//   SIZE  : width of one affine coordinate in bits
//   NIB   : width of the 4-bit pad bus
//   NIBS  : nibbles per coordinate
//   CNT_W : width of the per-coordinate nibble counter
package ecc_pkg;

  localparam int unsigned SIZE  = 32;
  localparam int unsigned NIB   = 4;
  localparam int unsigned NIBS  = SIZE / NIB;
  localparam int unsigned CNT_W = (NIBS > 1) ? $clog2(NIBS) : 1;

  // State encoding is fixed so it matches the legacy 2-bit codes.
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SEND_X = 2'd1;
  localparam state_t ST_SEND_Y = 2'd2;

endpackage : ecc_pkg

// File: rtl/kp_result_unloader_shift.sv
// nibble_shift_reg
//   SIZE-bit register with parallel load and right shift by NIB bits.
//   Ports:
//     i_clk, i_rst : clock, asynchronous active-high reset (clears to 0)
//     load_i       : load data_i (has priority over shift_i)
//     shift_i      : shift right by NIB, zero filling from the top
//     data_i       : parallel load value
//     nib_d_o      : low nibble the register will hold after this edge
//   The look-ahead nibble lets the owner register its output nibble
//   directly, so the pad bus is driven from a flop without extra latency.
module nibble_shift_reg
  import ecc_pkg::*;
#(
  parameter int unsigned SIZE = ecc_pkg::SIZE,
  parameter int unsigned NIB  = ecc_pkg::NIB
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            load_i,
  input  logic            shift_i,
  input  logic [SIZE-1:0] data_i,
  output logic [NIB-1:0]  nib_d_o
);

  logic [SIZE-1:0] sh_q;
  logic [SIZE-1:0] sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load_i) begin
      sh_d = data_i;
    end else if (shift_i) begin
      sh_d = sh_q >> NIB;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign nib_d_o = sh_d[NIB-1:0];

endmodule : nibble_shift_reg

// File: rtl/kp_result_unloader.sv
// kp_result_unloader
//   Captures the x/y result of kP on i_done and streams both coordinates out
//   on the 4-bit pad bus, least-significant nibble first, x before y, one
//   nibble per valid/ready handshake.
//   Ports:
//     i_clk, i_rst : clock, asynchronous active-high reset
//     i_done       : one-cycle completion pulse from Control
//     i_x, i_y     : result coordinates, sampled only on an accepted i_done
//     i_ready      : downstream accepts the current nibble
//     o_kP         : current nibble
//     o_valid      : o_kP is valid
//     o_sel        : 0 = x nibble, 1 = y nibble
//     o_last       : final y nibble
//     o_busy       : stream in progress
//     o_drop       : one-cycle pulse, i_done ignored because busy
//   All outputs are flops; their next values are derived from the next FSM
//   state and the shift registers' look-ahead nibbles.
module kp_result_unloader
  import ecc_pkg::*;
#(
  parameter int unsigned SIZE = ecc_pkg::SIZE,
  parameter int unsigned NIB  = ecc_pkg::NIB
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_done,
  input  logic [SIZE-1:0] i_x,
  input  logic [SIZE-1:0] i_y,
  input  logic            i_ready,
  output logic [NIB-1:0]  o_kP,
  output logic            o_valid,
  output logic            o_sel,
  output logic            o_last,
  output logic            o_busy,
  output logic            o_drop
);

  localparam int unsigned NIBS  = SIZE / NIB;
  localparam int unsigned CNT_W = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NIB-1:0] kp_q, kp_d;
  logic           valid_q, valid_d;
  logic           sel_q, sel_d;
  logic           last_q, last_d;
  logic           busy_q, busy_d;
  logic           drop_q, drop_d;

  logic           hs;
  logic           load;
  logic           shift_x;
  logic           shift_y;
  logic [NIB-1:0] x_nib_d;
  logic [NIB-1:0] y_nib_d;

  assign hs      = valid_q & i_ready;
  assign load    = (state_q == ST_IDLE) & i_done;
  assign shift_x = (state_q == ST_SEND_X) & hs;
  assign shift_y = (state_q == ST_SEND_Y) & hs;

  nibble_shift_reg #(
    .SIZE (SIZE),
    .NIB  (NIB)
  ) u_x_sh (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .load_i  (load),
    .shift_i (shift_x),
    .data_i  (i_x),
    .nib_d_o (x_nib_d)
  );

  nibble_shift_reg #(
    .SIZE (SIZE),
    .NIB  (NIB)
  ) u_y_sh (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .load_i  (load),
    .shift_i (shift_y),
    .data_i  (i_y),
    .nib_d_o (y_nib_d)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_done) begin
          state_d = ST_SEND_X;
          cnt_d   = '0;
        end
      end
      ST_SEND_X: begin
        if (hs) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_SEND_Y;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_SEND_Y: begin
        if (hs) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output flops follow the state being entered, so the first x nibble is
  // presented the cycle after capture and nothing changes while stalled.
  always_comb begin
    valid_d = (state_d != ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    sel_d   = (state_d == ST_SEND_Y);
    last_d  = (state_d == ST_SEND_Y) && (cnt_d == CNT_LAST);
    drop_d  = i_done && (state_q != ST_IDLE);
    kp_d    = '0;
    if (state_d == ST_SEND_X) begin
      kp_d = x_nib_d;
    end else if (state_d == ST_SEND_Y) begin
      kp_d = y_nib_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      kp_q    <= '0;
      valid_q <= 1'b0;
      sel_q   <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kp_q    <= kp_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  assign o_kP    = kp_q;
  assign o_valid = valid_q;
  assign o_sel   = sel_q;
  assign o_last  = last_q;
  assign o_busy  = busy_q;
  assign o_drop  = drop_q;

endmodule : kp_result_unloader

// File: tb/tb_kp_result_unloader.sv
module tb_kp_result_unloader;

  logic        clk;
  logic        rst;
  logic        done;
  logic [31:0] x;
  logic [31:0] y;
  logic        ready;
  logic [3:0]  kp;
  logic        valid;
  logic        sel;
  logic        last;
  logic        busy;
  logic        drop;

  int unsigned n_checks;
  int unsigned n_fail;

  // Expected stream for x=87654321, y=FEDCBA98 (low nibble first, x then y).
  logic [3:0] basic_tbl [16] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
                                 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

  kp_result_unloader #(
    .SIZE (32),
    .NIB  (4)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_done  (done),
    .i_x     (x),
    .i_y     (y),
    .i_ready (ready),
    .o_kP    (kp),
    .o_valid (valid),
    .o_sel   (sel),
    .o_last  (last),
    .o_busy  (busy),
    .o_drop  (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; done = 1'b0; x = '0; y = '0; ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({valid, sel, last, busy, drop, kp} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_state: got v%b s%b l%b b%b d%b kP=%h, want all 0",
               valid, sel, last, busy, drop, kp);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({valid, busy, kp} !== 6'd0) begin
      n_fail++;
      $display("FAIL after_reset_idle: got v%b b%b kP=%h, want 0", valid, busy, kp);
    end
  endtask

  task automatic test_basic_stream();
    @(negedge clk);
    x = 32'h87654321; y = 32'hFEDCBA98; done = 1'b1; ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      done = 1'b0;
      n_checks++;
      if ({busy, valid, sel, last, kp} !== {1'b1, 1'b1, (k >= 8), (k == 15), basic_tbl[k]}) begin
        n_fail++;
        $display("FAIL basic_nib%0d: got b%b v%b s%b l%b kP=%h, want b1 v1 s%b l%b kP=%h",
                 k, busy, valid, sel, last, kp, (k >= 8), (k == 15), basic_tbl[k]);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({valid, busy, last} !== 3'b000) begin
      n_fail++;
      $display("FAIL basic_end: got v%b b%b l%b, want 000", valid, busy, last);
    end
  endtask

  task automatic test_backpressure();
    int unsigned idx;
    bit          finished;
    idx = 0;
    finished = 1'b0;
    @(negedge clk);
    x = 32'h87654321; y = 32'hFEDCBA98; done = 1'b1; ready = 1'b1;
    for (int c = 0; c < 100 && !finished; c++) begin
      @(negedge clk);
      done = 1'b0;
      x = 32'hDEADBEEF; y = 32'h0BADF00D;
      if (idx < 16) begin
        n_checks++;
        if ({valid, sel, last, kp} !== {1'b1, (idx >= 8), (idx == 15), basic_tbl[idx]}) begin
          n_fail++;
          $display("FAIL bp_nib%0d_cyc%0d: got v%b s%b l%b kP=%h, want v1 s%b l%b kP=%h",
                   idx, c, valid, sel, last, kp, (idx >= 8), (idx == 15), basic_tbl[idx]);
        end
        ready = ((c % 4) == 0) || ((c % 4) == 3);
        if (ready) idx++;
      end else begin
        n_checks++;
        if ({valid, busy} !== 2'b00) begin
          n_fail++;
          $display("FAIL bp_end: got v%b b%b, want 00", valid, busy);
        end
        finished = 1'b1;
      end
    end
    if (!finished) begin
      n_checks++;
      n_fail++;
      $display("FAIL bp_timeout: accepted %0d nibbles, want 16", idx);
    end
    ready = 1'b1;
  endtask

  task automatic test_overrun();
    @(negedge clk);
    x = 32'h87654321; y = 32'hFEDCBA98; done = 1'b1; ready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      done = 1'b0;
      n_checks++;
      if (drop !== ((k == 5) || (k == 16))) begin
        n_fail++;
        $display("FAIL ovr_drop_cyc%0d: got %b, want %b", k, drop, ((k == 5) || (k == 16)));
      end
      n_checks++;
      if (k < 16) begin
        if ({valid, sel, last, kp} !== {1'b1, (k >= 8), (k == 15), basic_tbl[k]}) begin
          n_fail++;
          $display("FAIL ovr_nib%0d: got v%b s%b l%b kP=%h, want v1 s%b l%b kP=%h",
                   k, valid, sel, last, kp, (k >= 8), (k == 15), basic_tbl[k]);
        end
      end else if ({valid, busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL ovr_idle_cyc%0d: got v%b b%b, want 00", k, valid, busy);
      end
      if (k == 4 || k == 15) begin
        done = 1'b1; x = 32'h11111111; y = 32'h22222222;
      end
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    x = 32'h87654321; y = 32'hFEDCBA98; done = 1'b1; ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      done = 1'b0;
      n_checks++;
      if ({valid, sel, kp} !== {1'b1, (k >= 8), basic_tbl[k]}) begin
        n_fail++;
        $display("FAIL rstm_nib%0d: got v%b s%b kP=%h, want v1 s%b kP=%h",
                 k, valid, sel, kp, (k >= 8), basic_tbl[k]);
      end
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({valid, sel, last, busy, drop, kp} !== 9'd0) begin
      n_fail++;
      $display("FAIL rstm_async: got v%b s%b l%b b%b d%b kP=%h, want all 0",
               valid, sel, last, busy, drop, kp);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    x = 32'h0000000F; y = 32'h00000000; done = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      done = 1'b0;
      n_checks++;
      if ({drop, valid, sel, last, kp} !==
          {1'b0, 1'b1, (k >= 8), (k == 15), ((k == 0) ? 4'hF : 4'h0)}) begin
        n_fail++;
        $display("FAIL rstm_new_nib%0d: got d%b v%b s%b l%b kP=%h, want d0 v1 s%b l%b kP=%h",
                 k, drop, valid, sel, last, kp, (k >= 8), (k == 15), ((k == 0) ? 4'hF : 4'h0));
      end
    end
    @(negedge clk);
    n_checks++;
    if ({valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL rstm_new_end: got v%b b%b, want 00", valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    x = 32'h87654321; y = 32'hFEDCBA98; done = 1'b1; ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      done = 1'b0;
    end
    n_checks++;
    if ({valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_first_end: got v%b b%b, want 00", valid, busy);
    end
    @(negedge clk);
    x = 32'hAAAAAAAA; y = 32'h55555555; done = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      done = 1'b0;
      n_checks++;
      if ({drop, valid, sel, last, kp} !==
          {1'b0, 1'b1, (k >= 8), (k == 15), ((k < 8) ? 4'hA : 4'h5)}) begin
        n_fail++;
        $display("FAIL b2b_nib%0d: got d%b v%b s%b l%b kP=%h, want d0 v1 s%b l%b kP=%h",
                 k, drop, valid, sel, last, kp, (k >= 8), (k == 15), ((k < 8) ? 4'hA : 4'h5));
      end
    end
    @(negedge clk);
    n_checks++;
    if ({valid, busy, drop} !== 3'b000) begin
      n_fail++;
      $display("FAIL b2b_end: got v%b b%b d%b, want 000", valid, busy, drop);
    end
  endtask

  task automatic test_idle_stability();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      n_checks++;
      if ({valid, busy, drop, kp} !== 7'd0) begin
        n_fail++;
        $display("FAIL idle_cyc%0d: got v%b b%b d%b kP=%h, want 0", k, valid, busy, drop, kp);
      end
      done = 1'b0; ready = 1'b1; x = $urandom; y = $urandom;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_overrun();
    test_reset_midstream();
    test_back_to_back();
    test_idle_stability();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_kp_result_unloader
